// File: rtl/button_debounce.sv
// button_debounce: turns a raw, bouncing button or switch pin into a clean
// registered level (button_clean) plus a one-cycle press strobe (button_press).
// Build option: define DEBOUNCE_ACTIVE_LOW_EN to invert the pin before the
// synchroniser, for active-low board KEYs. The default build is active-high.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 2500000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic button_raw,
  output logic button_clean,
  output logic button_press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    WAIT_HIGH   = 2'd1,
    STABLE_HIGH = 2'd2,
    WAIT_LOW    = 2'd3
  } state_t;

  logic                   raw_logical;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   s;
  state_t                 state_q;
  state_t                 state_d;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;
  logic                   clean_q;
  logic                   clean_d;
  logic                   press_q;
  logic                   press_d;

`ifdef DEBOUNCE_ACTIVE_LOW_EN
  assign raw_logical = ~button_raw;
`else
  assign raw_logical = button_raw;
`endif

  assign s = sync_q[SYNC_STAGES-1];

  // Synchroniser chain: shift the logical pin level one stage per clock.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], raw_logical};
  end

  // Stability FSM: a new level must be seen on s for DEBOUNCE_CYCLES cycles in a row.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clean_d = clean_q;
    press_d = 1'b0;
    case (state_q)
      STABLE_LOW: begin
        if (s) begin
          state_d = WAIT_HIGH;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = CNT_ZERO;
        end
      end
      WAIT_HIGH: begin
        if (!s) begin
          state_d = STABLE_LOW;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_HIGH;
          cnt_d   = CNT_ZERO;
          clean_d = 1'b1;
          press_d = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      STABLE_HIGH: begin
        if (!s) begin
          state_d = WAIT_LOW;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = CNT_ZERO;
        end
      end
      WAIT_LOW: begin
        if (s) begin
          state_d = STABLE_HIGH;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_LOW;
          cnt_d   = CNT_ZERO;
          clean_d = 1'b0;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = STABLE_LOW;
        cnt_d   = CNT_ZERO;
        clean_d = 1'b0;
      end
    endcase
  end

  // State, counter, synchroniser and output registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '0;
      state_q <= STABLE_LOW;
      cnt_q   <= CNT_ZERO;
      clean_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      press_q <= press_d;
    end
  end

  assign button_clean = clean_q;
  assign button_press = press_q;

endmodule

// File: tb/tb_button_debounce.sv
// Testbench for button_debounce with DEBOUNCE_CYCLES=8, SYNC_STAGES=2.
// Stimulus is written in logical levels and converted to pin levels, so the
// same directed sequence covers both the default and DEBOUNCE_ACTIVE_LOW_EN builds.
module tb_button_debounce;

`ifdef DEBOUNCE_ACTIVE_LOW_EN
  localparam logic ACTIVE_LOW = 1'b1;
`else
  localparam logic ACTIVE_LOW = 1'b0;
`endif

  typedef struct {
    logic  clean;
    logic  press;
    string tag;
  } expect_t;

  logic clk;
  logic reset;
  logic button_raw;
  logic button_clean;
  logic button_press;

  expect_t scoreboard[$];
  int      checks;
  int      errors;

  button_debounce #(
    .DEBOUNCE_CYCLES(8),
    .SYNC_STAGES    (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .button_raw  (button_raw),
    .button_clean(button_clean),
    .button_press(button_press)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // Pop the expectation for this edge and compare both outputs against it.
  task automatic checkOutput();
    expect_t e;
    if (scoreboard.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_empty: got no entry, required one entry");
    end else begin
      e = scoreboard.pop_front();
      checks++;
      assert (button_clean === e.clean)
      else begin
        errors++;
        $error("[TB] FAIL %s clean: got %b required %b", e.tag, button_clean, e.clean);
      end
      checks++;
      assert (button_press === e.press)
      else begin
        errors++;
        $error("[TB] FAIL %s press: got %b required %b", e.tag, button_press, e.press);
      end
    end
  endtask

  // Drive one cycle of inputs, queue the outputs expected after the next edge, then check.
  task automatic applyStimulus(input logic rst, input logic level,
                               input logic expClean, input logic expPress,
                               input string tag);
    expect_t e;
    reset      = rst;
    button_raw = level ^ ACTIVE_LOW;
    e.clean    = expClean;
    e.press    = expPress;
    e.tag      = tag;
    scoreboard.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  // Repeat the same inputs and expectations (no press) for n cycles.
  task automatic holdCycles(input logic rst, input logic level, input int n,
                            input logic expClean, input string tag);
    for (int i = 0; i < n; i++) begin
      applyStimulus(rst, level, expClean, 1'b0, tag);
    end
  endtask

  // Directed sequence; edge counts are from the cycle the new level is driven.
  initial begin
    clk        = 1'b0;
    reset      = 1'b1;
    button_raw = ACTIVE_LOW;
    checks     = 0;
    errors     = 0;

    // Reset held 3 cycles with the button pressed: outputs stay low.
    holdCycles(1'b1, 1'b1, 3, 1'b0, "reset_hold");
    // After release the pressed level must qualify: rise on the 10th edge.
    holdCycles(1'b0, 1'b1, 9, 1'b0, "release_qual");
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, "release_rise");
    holdCycles(1'b0, 1'b1, 3, 1'b1, "release_hold");

    // Clean release: falls on the 10th edge without a press strobe.
    holdCycles(1'b0, 1'b0, 9, 1'b1, "fall_qual");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, "fall_edge");
    holdCycles(1'b0, 1'b0, 3, 1'b0, "fall_hold");

    // Clean press from a settled low.
    holdCycles(1'b0, 1'b1, 9, 1'b0, "press_qual");
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, "press_rise");
    holdCycles(1'b0, 1'b1, 2, 1'b1, "press_hold");
    holdCycles(1'b0, 1'b0, 9, 1'b1, "press_release");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, "press_fall");
    holdCycles(1'b0, 1'b0, 3, 1'b0, "press_low");

    // Bounce 1,0,1,1,0 then hold 1: rise 10 edges after the final 0->1.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, "bounce");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, "bounce");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, "bounce");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, "bounce");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, "bounce");
    holdCycles(1'b0, 1'b1, 9, 1'b0, "bounce_qual");
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, "bounce_rise");
    holdCycles(1'b0, 1'b1, 2, 1'b1, "bounce_hold");
    holdCycles(1'b0, 1'b0, 9, 1'b1, "bounce_release");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, "bounce_fall");
    holdCycles(1'b0, 1'b0, 3, 1'b0, "bounce_low");

    // High for 7 cycles is one short of qualifying: nothing happens.
    holdCycles(1'b0, 1'b1, 7, 1'b0, "glitch7_high");
    holdCycles(1'b0, 1'b0, 12, 1'b0, "glitch7_low");

    // High for exactly 8 cycles qualifies: press on edge 10, clean back low on edge 18.
    holdCycles(1'b0, 1'b1, 8, 1'b0, "glitch8_high");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, "glitch8_low");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, "glitch8_rise");
    holdCycles(1'b0, 1'b0, 7, 1'b1, "glitch8_clean");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, "glitch8_fall");
    holdCycles(1'b0, 1'b0, 3, 1'b0, "glitch8_settle");

    // Reset when the counter has reached 5 in WAIT_HIGH, then full requalification.
    holdCycles(1'b0, 1'b1, 7, 1'b0, "midqual_count");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, "midqual_reset");
    holdCycles(1'b0, 1'b1, 9, 1'b0, "midqual_requal");
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, "midqual_rise");
    holdCycles(1'b0, 1'b1, 2, 1'b1, "midqual_hold");

    // Reset while the clean level is high forces it low immediately.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, "reset_from_high");
    holdCycles(1'b1, 1'b0, 2, 1'b0, "reset_low");
    holdCycles(1'b0, 1'b0, 4, 1'b0, "final_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
